// File: rtl/cic_interp_pkg.sv
// Shared constants and helpers for the CIC interpolator and its decimator counterpart.
package cic_interp_pkg;

  localparam int unsigned CicNStages = 3;
  localparam int unsigned CicAccW    = 40;
  localparam int unsigned CicRBase   = 16;
  localparam int unsigned PhaseW     = 11;  // holds R-1 up to 2047

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } cic_state_e;

  // Output scaling that removes the R^2 DC gain: log2(R^2) = 2*(4 + rate_sel).
  function automatic logic [4:0] rate_shift(input logic [2:0] rate_sel);
    return 5'(2 * (4 + int'(rate_sel)));
  endfunction

  // Last phase-counter value for a given ratio, i.e. R-1.
  function automatic logic [PhaseW-1:0] rate_last(input logic [2:0] rate_sel);
    return PhaseW'((CicRBase << rate_sel) - 1);
  endfunction

endpackage

// File: rtl/cic_integrator.sv
// One wrapping accumulator stage of the CIC integrator chain.
module cic_integrator
  import cic_interp_pkg::*;
#(
  parameter int unsigned Width = CicAccW
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic [Width-1:0] in_i,
  output logic [Width-1:0] acc_o
);

  logic [Width-1:0] acc_q;

  // Accumulate every cycle with modulo-2^Width wrap; clr_i flushes to zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_q + in_i;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/cic_interp.sv
// Three-stage CIC interpolator: low-rate combs, zero-stuffing, high-rate integrators.
module cic_interp
  import cic_interp_pkg::*;
#(
  parameter int unsigned N_STAGES = CicNStages,
  parameter int unsigned ACC_W    = CicAccW
) (
  input  logic        CLK,
  input  logic        RSTb,
  input  logic        en,
  input  logic [2:0]  rate_sel,
  input  logic [15:0] x_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] y_out,
  output logic        out_tick,
  output logic        underrun
);

  cic_state_e        state_q, state_d;
  logic [2:0]        rate_q, rate_d;
  logic [PhaseW-1:0] phase_q, phase_d;
  logic [15:0]       samp_q, samp_d;
  logic [ACC_W-1:0]  dly_q [N_STAGES];
  logic [ACC_W-1:0]  dly_d [N_STAGES];
  logic [ACC_W-1:0]  stuff_q, stuff_d;
  logic              stuff_v_q, stuff_v_d;
  logic [15:0]       y_q, y_d;
  logic              tick_q, tick_d;

  logic              active;
  logic [15:0]       cur_samp;
  logic [ACC_W-1:0]  comb_v [N_STAGES+1];
  logic [ACC_W-1:0]  int_in;
  logic [ACC_W-1:0]  acc [N_STAGES];

  // en low overrides everything in the same cycle, including a pending request.
  assign active   = (state_q == StRun) && en;
  assign in_ready = (state_q == StRun) && (phase_q == rate_last(rate_q));
  assign underrun = in_ready && !in_valid;

  // Run/idle control; the ratio is frozen on entry to RUN.
  always_comb begin
    state_d = state_q;
    rate_d  = rate_q;
    unique case (state_q)
      StIdle: begin
        if (en) begin
          state_d = StRun;
          rate_d  = rate_sel;
        end
      end
      StRun: begin
        if (!en) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Phase counter, sample capture, comb section and output stage; all zero when not active.
  always_comb begin
    phase_d   = '0;
    samp_d    = '0;
    dly_d     = '{default: '0};
    stuff_d   = '0;
    stuff_v_d = 1'b0;
    y_d       = '0;
    tick_d    = 1'b0;
    cur_samp  = samp_q;
    comb_v    = '{default: '0};
    if (active) begin
      phase_d = in_ready ? '0 : phase_q + 1'b1;
      samp_d  = samp_q;
      dly_d   = dly_q;
      tick_d  = 1'b1;
      y_d     = 16'($signed(acc[N_STAGES-1]) >>> rate_shift(rate_q));
      if (in_ready) begin
        // Missing data repeats the held sample rather than injecting a zero.
        if (in_valid) cur_samp = x_in;
        samp_d    = cur_samp;
        comb_v[0] = {{(ACC_W-16){cur_samp[15]}}, cur_samp};
        for (int k = 0; k < N_STAGES; k++) begin
          comb_v[k+1] = comb_v[k] - dly_q[k];
          dly_d[k]    = comb_v[k];
        end
        stuff_d   = comb_v[N_STAGES];
        stuff_v_d = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state_q   <= StIdle;
      rate_q    <= '0;
      phase_q   <= '0;
      samp_q    <= '0;
      dly_q     <= '{default: '0};
      stuff_q   <= '0;
      stuff_v_q <= 1'b0;
      y_q       <= '0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rate_q    <= rate_d;
      phase_q   <= phase_d;
      samp_q    <= samp_d;
      dly_q     <= dly_d;
      stuff_q   <= stuff_d;
      stuff_v_q <= stuff_v_d;
      y_q       <= y_d;
      tick_q    <= tick_d;
    end
  end

  // Zero-stuffed feed into the first integrator.
  assign int_in = stuff_v_q ? stuff_q : '0;

  for (genvar k = 0; k < N_STAGES; k++) begin : g_integ
    logic [ACC_W-1:0] stage_in;
    if (k == 0) begin : g_head
      assign stage_in = int_in;
    end else begin : g_tail
      assign stage_in = acc[k-1];
    end
    cic_integrator #(
      .Width(ACC_W)
    ) u_integ (
      .clk_i (CLK),
      .rst_ni(RSTb),
      .clr_i (!active),
      .in_i  (stage_in),
      .acc_o (acc[k])
    );
  end

  assign y_out    = y_q;
  assign out_tick = tick_q;

endmodule

// File: tb/tb_cic_interp.sv
// Self-checking bench for cic_interp against an FIR-convolution reference model.
module tb_cic_interp;

  logic        CLK = 1'b0;
  logic        RSTb;
  logic        en;
  logic [2:0]  rate_sel;
  logic [15:0] x_in;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] y_out;
  logic        out_tick;
  logic        underrun;

  cic_interp dut (
    .CLK     (CLK),
    .RSTb    (RSTb),
    .en      (en),
    .rate_sel(rate_sel),
    .x_in    (x_in),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .y_out   (y_out),
    .out_tick(out_tick),
    .underrun(underrun)
  );

  always #5 CLK = ~CLK;

  int    n_checks = 0;
  int    n_fail   = 0;
  longint cyc     = 0;

  // Reference model: the interpolator is upsample-by-R followed by the FIR h = box_R * box_R * box_R,
  // then floor division by R^2. Accepted (or repeated) samples are impulses at their accept edge.
  typedef struct {
    longint t;
    longint v;
  } acc_t;

  acc_t        q[$];
  bit          m_run   = 1'b0;
  longint      m_start = 0;
  int          m_R     = 16;
  logic [15:0] m_last  = '0;
  longint      h[0:6143];

  function automatic longint h2(int r, int k);
    if (k < 0) return 0;
    if (k < r) return longint'(k + 1);
    if (k <= 2 * r - 2) return longint'(2 * r - 1 - k);
    return 0;
  endfunction

  function automatic void build_h(int r);
    longint run_sum;
    run_sum = 0;
    for (int k = 0; k <= 3 * r - 3; k++) begin
      run_sum += h2(r, k);
      if (k >= r) run_sum -= h2(r, k - r);
      h[k] = run_sum;
    end
  endfunction

  function automatic longint model_y(longint e);
    longint s, d, qq;
    s = 0;
    foreach (q[i]) begin
      longint k;
      k = e - 4 - q[i].t;
      if (k >= 0 && k <= longint'(3 * m_R - 3)) s += h[int'(k)] * q[i].v;
    end
    d  = longint'(m_R) * longint'(m_R);
    qq = s / d;
    if ((s % d != 0) && (s < 0)) qq -= 1;
    return qq;
  endfunction

  // One clock: check handshake outputs before the edge, advance the model, check outputs after it.
  task automatic step(output logic rdy, output logic ur);
    longint      e;
    logic        exp_ready, exp_tick;
    logic [15:0] ey;
    e         = cyc + 1;
    exp_ready = m_run && (((e - m_start) % longint'(m_R)) == 0);
    exp_tick  = m_run && en && RSTb;
    #1;
    rdy = in_ready;
    ur  = underrun;
    n_checks++;
    if (in_ready !== exp_ready) begin
      n_fail++;
      $display("FAIL in_ready edge %0d: got %b want %b", e, in_ready, exp_ready);
    end
    n_checks++;
    if (underrun !== (exp_ready && !in_valid)) begin
      n_fail++;
      $display("FAIL underrun edge %0d: got %b want %b", e, underrun, exp_ready && !in_valid);
    end
    if (RSTb) begin
      if (m_run && !en) begin
        m_run  = 1'b0;
        q.delete();
        m_last = '0;
      end else if (m_run) begin
        if (exp_ready) begin
          if (in_valid) m_last = x_in;
          q.push_back('{e, longint'($signed(m_last))});
        end
      end else if (en) begin
        m_run   = 1'b1;
        m_start = e;
        m_R     = 16 << rate_sel;
        build_h(m_R);
      end
    end
    @(posedge CLK);
    cyc++;
    #1;
    while (q.size() > 0 && (cyc - 4 - q[0].t) > longint'(3 * m_R - 3)) void'(q.pop_front());
    ey = 16'(model_y(cyc));
    n_checks++;
    if (y_out !== ey) begin
      n_fail++;
      $display("FAIL y_out edge %0d: got %0d want %0d", cyc, $signed(y_out), $signed(ey));
    end
    n_checks++;
    if (out_tick !== exp_tick) begin
      n_fail++;
      $display("FAIL out_tick edge %0d: got %b want %b", cyc, out_tick, exp_tick);
    end
    @(negedge CLK);
  endtask

  task automatic flush();
    logic r, u;
    en = 1'b0;
    step(r, u);
    step(r, u);
  endtask

  task automatic test_reset();
    logic   r, u;
    longint e0, first, second;
    RSTb = 1'b0; en = 1'b1; rate_sel = 3'd0; x_in = '0; in_valid = 1'b0;
    repeat (3) @(negedge CLK);
    n_checks++;
    if (y_out !== 16'd0) begin n_fail++; $display("FAIL reset_y: got %0d want 0", y_out); end
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", in_ready); end
    n_checks++;
    if (out_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b want 0", out_tick); end
    n_checks++;
    if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b want 0", underrun); end
    RSTb = 1'b1;
    e0 = cyc + 1; first = -1; second = -1;
    for (int i = 0; i < 60 && second < 0; i++) begin
      step(r, u);
      if (r) begin
        if (first < 0) first = cyc;
        else second = cyc;
      end
    end
    n_checks++;
    if (first - e0 != 16) begin
      n_fail++; $display("FAIL first_ready: got %0d want 16", first - e0);
    end
    n_checks++;
    if (second - first != 16) begin
      n_fail++; $display("FAIL ready_period: got %0d want 16", second - first);
    end
  endtask

  task automatic test_dc_step();
    logic   r, u;
    longint ta;
    int     bad;
    flush();
    rate_sel = 3'd0; x_in = 16'd1000; in_valid = 1'b1; en = 1'b1;
    ta = -1;
    for (int i = 0; i < 200 && (ta < 0 || cyc < ta + 52); i++) begin
      step(r, u);
      if (r && ta < 0) ta = cyc;
    end
    n_checks++;
    if (ta < 0 || y_out !== 16'd1000) begin
      n_fail++; $display("FAIL dc_settle: got %0d want 1000", $signed(y_out));
    end
    bad = 0;
    repeat (1000) begin
      step(r, u);
      if (y_out !== 16'd1000) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL dc_hold: got %0d deviations want 0", bad); end
  endtask

  task automatic test_extreme();
    logic        r, u;
    logic [15:0] vals[2];
    vals[0] = 16'h8000;
    vals[1] = 16'h7fff;
    foreach (vals[j]) begin
      flush();
      rate_sel = 3'd7; x_in = vals[j]; in_valid = 1'b1; en = 1'b1;
      repeat (4 * 2048 + 40) step(r, u);
      n_checks++;
      if (y_out !== vals[j]) begin
        n_fail++;
        $display("FAIL extreme: got %0d want %0d", $signed(y_out), $signed(vals[j]));
      end
    end
  endtask

  task automatic test_underrun();
    logic r, u;
    int   nrdy, nur, mis, bad;
    flush();
    rate_sel = 3'd1; x_in = 16'd500; in_valid = 1'b1; en = 1'b1;
    nrdy = 0;
    for (int i = 0; i < 400 && nrdy < 5; i++) begin
      step(r, u);
      if (r) nrdy++;
    end
    n_checks++;
    if (y_out !== 16'd500) begin n_fail++; $display("FAIL ur_settle: got %0d want 500", y_out); end
    in_valid = 1'b0; x_in = 16'h7abc;
    nrdy = 0; nur = 0; mis = 0; bad = 0;
    for (int i = 0; i < 200 && nrdy < 3; i++) begin
      step(r, u);
      if (r) nrdy++;
      if (u) nur++;
      if (u && !r) mis++;
      if (y_out !== 16'd500) bad++;
    end
    n_checks++;
    if (nur != 3) begin n_fail++; $display("FAIL ur_count: got %0d want 3", nur); end
    n_checks++;
    if (mis != 0) begin n_fail++; $display("FAIL ur_align: got %0d want 0", mis); end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL ur_hold: got %0d deviations want 0", bad); end
    in_valid = 1'b1; x_in = 16'd500;
    repeat (40) step(r, u);
  endtask

  task automatic test_flush();
    logic   r, u;
    longint e0, first, second;
    flush();
    rate_sel = 3'd0; x_in = 16'd1000; in_valid = 1'b1; en = 1'b1;
    repeat (120) step(r, u);
    n_checks++;
    if (y_out !== 16'd1000) begin n_fail++; $display("FAIL flush_pre: got %0d want 1000", y_out); end
    en = 1'b0;
    step(r, u);
    n_checks++;
    if (y_out !== 16'd0) begin n_fail++; $display("FAIL flush_y: got %0d want 0", y_out); end
    n_checks++;
    if (out_tick !== 1'b0) begin n_fail++; $display("FAIL flush_tick: got %b want 0", out_tick); end
    rate_sel = 3'd2; en = 1'b1;
    e0 = cyc + 1; first = -1; second = -1;
    for (int i = 0; i < 300 && second < 0; i++) begin
      step(r, u);
      rate_sel = 3'd0;  // must be ignored while running
      if (r) begin
        if (first < 0) first = cyc;
        else second = cyc;
      end
    end
    n_checks++;
    if (first - e0 != 64) begin n_fail++; $display("FAIL flush_first: got %0d want 64", first - e0); end
    n_checks++;
    if (second - first != 64) begin
      n_fail++; $display("FAIL flush_period: got %0d want 64", second - first);
    end
  endtask

  task automatic test_impulse();
    logic   r, u;
    longint ta, first_nz, sum;
    flush();
    rate_sel = 3'd0; x_in = 16'd16384; in_valid = 1'b1; en = 1'b1;
    ta = -1;
    for (int i = 0; i < 100 && ta < 0; i++) begin
      step(r, u);
      if (r) ta = cyc;
    end
    x_in = '0;
    sum = 0; first_nz = -1;
    repeat (60) begin
      step(r, u);
      if (y_out != 16'd0 && first_nz < 0) first_nz = cyc;
      sum += longint'($signed(y_out));
    end
    n_checks++;
    if (ta < 0 || first_nz != ta + 4) begin
      n_fail++; $display("FAIL imp_latency: got %0d want %0d", first_nz - ta, 4);
    end
    n_checks++;
    if (sum < 262144 - 48 || sum > 262144 + 48) begin
      n_fail++; $display("FAIL imp_sum: got %0d want 262144", sum);
    end
  endtask

  task automatic test_async_reset();
    logic r, u;
    flush();
    rate_sel = 3'd0; x_in = 16'd1234; in_valid = 1'b1; en = 1'b1;
    repeat (80) step(r, u);
    #2 RSTb = 1'b0;
    #1;
    n_checks++;
    if (y_out !== 16'd0) begin n_fail++; $display("FAIL areset_y: got %0d want 0", y_out); end
    n_checks++;
    if (out_tick !== 1'b0) begin n_fail++; $display("FAIL areset_tick: got %b want 0", out_tick); end
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL areset_ready: got %b want 0", in_ready); end
    m_run = 1'b0; q.delete(); m_last = '0;
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
    RSTb = 1'b1;
    repeat (80) step(r, u);
  endtask

  task automatic test_random();
    logic r, u;
    flush();
    repeat (4000) begin
      rate_sel = 3'($urandom_range(0, 2));
      x_in     = 16'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      en       = ($urandom_range(0, 499) != 0);
      step(r, u);
    end
  endtask

  initial begin
    test_reset();
    test_dc_step();
    test_extreme();
    test_underrun();
    test_flush();
    test_impulse();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
